// File: rtl/pe_config_loader.sv
// -----------------------------------------------------------------------------
// pe_config_loader
//
// Buffers configuration entries for a PE array in a small FIFO. On a start
// request it drains the FIFO onto init_PE_array/PE_config, one entry per
// cycle. It then waits RUN_GAP idle cycles, pulses run for one cycle, and
// finally pulses done for one cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   cfg_valid      producer offers an entry on cfg_data
//   cfg_ready      entry accepted this cycle (FIFO not full)
//   cfg_data       {row[1:0], unit[2:0], instruction[PE_INST_W-1:0]}
//   start          request to drain the FIFO and then run (honoured in IDLE only)
//   busy           high whenever the loader is not idle
//   done           one-cycle pulse after run
//   init_PE_array  {row one-hot[3:0] (bit3=row 0), unit one-hot[4:0] (bit4=LSU)}
//   PE_config      instruction of the most recently issued entry
//   run            one-cycle start pulse to the PE array
//   err_bad_unit   sticky: an entry with unit index > 4 was issued
// -----------------------------------------------------------------------------
module pe_config_loader #(
    parameter int PE_INST_W  = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int RUN_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [PE_INST_W+4:0] cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [8:0]           init_PE_array,
    output logic [PE_INST_W-1:0] PE_config,
    output logic                 run,
    output logic                 err_bad_unit
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;
    localparam int DW = PE_INST_W + 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        RUN,
        DONE
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          fifo_empty, fifo_full;
    logic          push, pop;
    logic [DW-1:0] head;

    // ------------------------------------------------------------------ FSM
    state_t               state_q,   state_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [8:0]           init_q,    init_d;
    logic [PE_INST_W-1:0] pe_cfg_q,  pe_cfg_d;
    logic                 err_q,     err_d;

    logic [1:0] head_row;
    logic [2:0] head_unit;
    logic [3:0] row_oh;
    logic [4:0] unit_oh;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        push       = cfg_valid && !fifo_full && !rst;
        pop        = (state_q == LOAD) && !fifo_empty;
        head       = mem_q[rd_ptr_q];

        // Depth is a power of two, so the pointers wrap on natural overflow.
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry decode: row r -> bit (3-r), unit u -> bit (4-u); units 5..7 select nothing.
    always_comb begin
        head_row  = head[PE_INST_W+4:PE_INST_W+3];
        head_unit = head[PE_INST_W+2:PE_INST_W];
        row_oh    = 4'b1000 >> head_row;
        unit_oh   = (head_unit <= 3'd4) ? (5'b10000 >> head_unit) : 5'b00000;
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        init_d    = init_q;
        pe_cfg_d  = pe_cfg_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                init_d = '0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Entries pushed while draining are seen here too, so they
                // go out in the same pass as long as the FIFO has not emptied.
                if (pop) begin
                    init_d   = {row_oh, unit_oh};
                    pe_cfg_d = head[PE_INST_W-1:0];
                    if (head_unit > 3'd4) begin
                        err_d = 1'b1;
                    end
                end else begin
                    init_d    = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                init_d = '0;
                if (gap_cnt_q == GW'(RUN_GAP - 1)) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            RUN: begin
                init_d  = '0;
                state_d = DONE;
            end
            DONE: begin
                init_d  = '0;
                state_d = IDLE;
            end
            default: begin
                init_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            init_q    <= '0;
            pe_cfg_q  <= '0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            init_q    <= init_d;
            pe_cfg_q  <= pe_cfg_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cfg_data;
        end
    end

    assign cfg_ready     = !fifo_full;
    assign busy          = (state_q != IDLE);
    assign run           = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign init_PE_array = init_q;
    assign PE_config     = pe_cfg_q;
    assign err_bad_unit  = err_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// -----------------------------------------------------------------------------
// tb_pe_config_loader
//
// Directed bench for pe_config_loader with default parameters
// (PE_INST_W=24, FIFO_DEPTH=16, RUN_GAP=2). Inputs change 1 ns after a
// rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_pe_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [28:0] cfg_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [8:0]  init_PE_array;
    logic [23:0] PE_config;
    logic        run;
    logic        err_bad_unit;

    int n_assert = 0;
    int n_fail   = 0;

    pe_config_loader #(
        .PE_INST_W (24),
        .FIFO_DEPTH(16),
        .RUN_GAP   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .init_PE_array(init_PE_array),
        .PE_config    (PE_config),
        .run          (run),
        .err_bad_unit (err_bad_unit)
    );

    always #5 clk = ~clk;

    // Array-test entries and their hand-derived init_PE_array codes.
    logic [1:0]  a_row  [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
    logic [2:0]  a_unit [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    logic [23:0] a_inst [9] = '{24'h966cf0, 24'h964cf0, 24'h964cf0, 24'h965d30,
                                24'h965d70, 24'h965d70, 24'h965d70, 24'h0007c0, 24'h0007c0};
    logic [8:0]  a_init [9] = '{9'b1000_01000, 9'b0100_01000, 9'b0010_01000, 9'b0001_01000,
                                9'b0001_00100, 9'b0001_00010, 9'b0001_00001, 9'b1000_10000,
                                9'b0100_10000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] r, input logic [2:0] u, input logic [23:0] inst);
        cfg_valid = 1'b1;
        cfg_data  = {r, u, inst};
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Start with an empty FIFO: LOAD(0 entries), GAP x2, RUN, DONE, IDLE.
    task automatic empty_run(input string tag, input logic exp_err);
        pulse_start();
        chk({tag, "_busy_T"}, busy, 1);
        step();
        chk({tag, "_init_T1"}, init_PE_array, 0);
        chk({tag, "_run_T1"}, run, 0);
        step();
        chk({tag, "_run_T2"}, run, 0);
        chk({tag, "_busy_T2"}, busy, 1);
        step();
        chk({tag, "_run_T3"}, run, 1);
        chk({tag, "_init_T3"}, init_PE_array, 0);
        step();
        chk({tag, "_done_T4"}, done, 1);
        chk({tag, "_run_T4"}, run, 0);
        chk({tag, "_busy_T4"}, busy, 1);
        step();
        chk({tag, "_busy_T5"}, busy, 0);
        chk({tag, "_done_T5"}, done, 0);
        chk({tag, "_err"}, err_bad_unit, exp_err);
    endtask

    initial begin
        logic [1:0] r;
        logic [2:0] u;
        logic [3:0] row_oh;
        logic [4:0] unit_oh;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        start     = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_run", run, 0);
        chk("rst_init", init_PE_array, 0);
        chk("rst_cfg", PE_config, 0);
        chk("rst_err", err_bad_unit, 0);

        // Array test: nine entries, start at edge T
        for (int i = 0; i < 9; i++) push(a_row[i], a_unit[i], a_inst[i]);
        pulse_start();
        chk("arr_busy_T", busy, 1);
        chk("arr_init_T", init_PE_array, 0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("arr_init_%0d", k), init_PE_array, a_init[k]);
            chk($sformatf("arr_cfg_%0d", k), PE_config, a_inst[k]);
            chk($sformatf("arr_run_%0d", k), run, 0);
        end
        step();  // T+10
        chk("arr_init_gap", init_PE_array, 0);
        chk("arr_cfg_hold", PE_config, 24'h0007c0);
        step();  // T+11
        chk("arr_run_T11", run, 0);
        step();  // T+12
        chk("arr_run_T12", run, 1);
        chk("arr_done_T12", done, 0);
        step();  // T+13
        chk("arr_done_T13", done, 1);
        chk("arr_run_T13", run, 0);
        step();
        chk("arr_busy_end", busy, 0);
        chk("arr_done_end", done, 0);
        chk("arr_err", err_bad_unit, 0);

        // Fill to full, reject a 17th entry, then drain exactly 16
        for (int k = 0; k < 16; k++) push(2'(k % 4), 3'(k % 5), 24'h100000 + 24'(k));
        chk("full_ready", cfg_ready, 0);
        push(2'd3, 3'd0, 24'hdead00);
        chk("full_ready_17", cfg_ready, 0);
        pulse_start();
        chk("full_ready_T", cfg_ready, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            r       = 2'(k % 4);
            u       = 3'(k % 5);
            row_oh  = 4'b1000 >> r;
            unit_oh = 5'b10000 >> u;
            if (k == 0) chk("full_ready_after_pop", cfg_ready, 1);
            chk($sformatf("full_init_%0d", k), init_PE_array, {row_oh, unit_oh});
            chk($sformatf("full_cfg_%0d", k), PE_config, 24'h100000 + 24'(k));
        end
        step();  // T+17
        chk("full_init_gap", init_PE_array, 0);
        chk("full_cfg_hold", PE_config, 24'h10000f);
        step();
        chk("full_run_T18", run, 0);
        step();
        chk("full_run_T19", run, 1);
        step();
        chk("full_done_T20", done, 1);
        step();
        chk("full_busy_end", busy, 0);

        // Bad unit index 6 on row 2
        push(2'd2, 3'd6, 24'habcdef);
        pulse_start();
        step();
        chk("bad_init", init_PE_array, 9'b0010_00000);
        chk("bad_cfg", PE_config, 24'habcdef);
        chk("bad_err", err_bad_unit, 1);
        step();
        step();
        step();
        chk("bad_run", run, 1);
        step();
        step();
        chk("bad_busy_end", busy, 0);

        // Empty-FIFO start; sticky error must persist
        empty_run("empty1", 1'b1);

        // Push during LOAD joins the pass; start during GAP is ignored
        push(2'd1, 3'd2, 24'h111111);
        start = 1'b1;
        step();  // T
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = {2'd2, 3'd3, 24'h222222};
        step();  // T+1: pop A, push B
        cfg_valid = 1'b0;
        chk("mid_init_A", init_PE_array, 9'b0100_00100);
        chk("mid_cfg_A", PE_config, 24'h111111);
        step();  // T+2
        chk("mid_init_B", init_PE_array, 9'b0010_00010);
        chk("mid_cfg_B", PE_config, 24'h222222);
        start = 1'b1;
        step();  // T+3 (start sampled in GAP here too)
        chk("mid_init_gap", init_PE_array, 0);
        step();  // T+4
        start = 1'b0;
        chk("mid_run_T4", run, 0);
        step();  // T+5
        chk("mid_run_T5", run, 1);
        step();  // T+6
        chk("mid_done_T6", done, 1);
        step();  // T+7
        chk("mid_busy_T7", busy, 0);
        step();
        chk("mid_busy_T8", busy, 0);
        step();
        chk("mid_run_T9", run, 0);
        chk("mid_err_hold", err_bad_unit, 1);

        // Reset in the middle of LOAD
        for (int i = 0; i < 9; i++) push(a_row[i], a_unit[i], a_inst[i]);
        pulse_start();
        step();
        step();
        step();  // T+3: entry 2 on outputs
        chk("rl_init_2", init_PE_array, a_init[2]);
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = {2'd0, 3'd1, 24'h333333};
        start     = 1'b1;
        step();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("rl_ready", cfg_ready, 1);
        chk("rl_busy", busy, 0);
        chk("rl_done", done, 0);
        chk("rl_run", run, 0);
        chk("rl_init", init_PE_array, 0);
        chk("rl_cfg", PE_config, 0);
        chk("rl_err", err_bad_unit, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rl_quiet_run_%0d", k), run, 0);
            chk($sformatf("rl_quiet_busy_%0d", k), busy, 0);
        end
        empty_run("empty2", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
